// File: rtl/rs_stream_par_encoder.sv
// Streaming systematic Reed-Solomon encoder: L symbols per beat, message beats pass through, parity beats follow.
// Optional in_last_i framing check is enabled by defining RS_ENC_FRAME_CHECK_EN.
module rs_stream_par_encoder #(
  parameter int         W         = 10,
  parameter logic [W:0] PRIM_POLY = 11'h409,
  parameter int         K         = 522,
  parameter int         R         = 22,
  parameter int         L         = 7,
  parameter logic [R*W-1:0] G_TAPS = {
    10'd513, 10'd783, 10'd899, 10'd452, 10'd976, 10'd555, 10'd482, 10'd374,
    10'd544, 10'd374, 10'd466, 10'd712, 10'd813, 10'd1010, 10'd657, 10'd365,
    10'd3,   10'd177, 10'd621, 10'd944, 10'd280, 10'd807}
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [L*W-1:0] in_data_i,
  input  logic           in_last_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [L*W-1:0] out_data_o,
  output logic [L-1:0]   out_keep_o,
  output logic           out_last_o,
  output logic           err_o
);

  // Handshake: a beat moves on a side exactly on a rising clk_i edge where valid and ready are
  // both high; a valid beat and its payload stay stable until that edge.

  localparam int ZP   = (L - K % L) % L;
  localparam int KB   = (K + ZP) / L;
  localparam int PB   = (R + L - 1) / L;
  localparam int BMAX = (KB > PB) ? KB : PB;
  localparam int BCW  = $clog2(BMAX + 1);

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  state_t                state_q;
  logic [BCW-1:0]        bcnt_q;
  logic [R-1:0][W-1:0]   rem_q;
  logic [R-1:0][W-1:0]   rem_d;
  logic [R-1:0][W-1:0]   par_q;
  logic                  out_valid_q;
  logic [L*W-1:0]        out_data_q;
  logic [L-1:0]          out_keep_q;
  logic                  out_last_q;

  logic                  out_free;
  logic                  accept;
  logic                  last_data;
  logic                  par_last;
  logic [L*W-1:0]        din_m;
  logic [L-1:0]          keep_d;
  logic [W-1:0]          lfsr_f;
  logic [PB*L*W-1:0]     par_seq;
  logic [PB*L-1:0]       par_keep;
  logic [L*W-1:0]        par_beat;
  logic [L-1:0]          par_beat_keep;

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] acc;
    logic [W-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[W-1] ? ((x << 1) ^ PRIM_POLY[W-1:0]) : (x << 1);
    end
    return acc;
  endfunction

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = !rst_ni && (state_q == S_DATA) && out_free;
  assign accept     = in_valid_i && in_ready_o;
  assign last_data  = (bcnt_q == BCW'(KB - 1));
  assign par_last   = (bcnt_q == BCW'(PB - 1));

  // Beat 0 carries the front padding that aligns the message to whole beats.
  always_comb begin
    din_m  = in_data_i;
    keep_d = '1;
    if (bcnt_q == '0) begin
      for (int j = 0; j < ZP; j++) begin
        din_m[j*W +: W] = '0;
        keep_d[j]       = 1'b0;
      end
    end
  end

  always_comb begin
    rem_d  = rem_q;
    lfsr_f = '0;
    for (int j = 0; j < L; j++) begin
      lfsr_f = rem_d[R-1] ^ din_m[j*W +: W];
      for (int i = R - 1; i > 0; i--) begin
        rem_d[i] = rem_d[i-1] ^ gf_mul(G_TAPS[i*W +: W], lfsr_f);
      end
      rem_d[0] = gf_mul(G_TAPS[W-1:0], lfsr_f);
    end
  end

  // Parity leaves highest degree first; lanes past the last parity symbol are empty.
  for (genvar m = 0; m < PB * L; m++) begin : g_par_map
    if (m < R) begin : g_sym
      assign par_seq[m*W +: W] = par_q[R-1-m];
      assign par_keep[m]       = 1'b1;
    end else begin : g_pad
      assign par_seq[m*W +: W] = '0;
      assign par_keep[m]       = 1'b0;
    end
  end

  always_comb begin
    par_beat      = '0;
    par_beat_keep = '0;
    for (int p = 0; p < PB; p++) begin
      if (int'(bcnt_q) == p) begin
        par_beat      = par_seq[p*L*W +: L*W];
        par_beat_keep = par_keep[p*L +: L];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q     <= S_DATA;
      bcnt_q      <= '0;
      rem_q       <= '0;
      par_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
      case (state_q)
        S_DATA: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= din_m;
            out_keep_q  <= keep_d;
            out_last_q  <= 1'b0;
            if (last_data) begin
              par_q   <= rem_d;
              rem_q   <= '0;
              bcnt_q  <= '0;
              state_q <= S_PAR;
            end else begin
              rem_q  <= rem_d;
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= par_beat;
            out_keep_q  <= par_beat_keep;
            out_last_q  <= par_last;
            if (par_last) begin
              bcnt_q  <= '0;
              state_q <= S_DATA;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;

`ifdef RS_ENC_FRAME_CHECK_EN
  // Sequencing follows bcnt only; a misplaced in_last_i is just reported.
  logic err_q;
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) err_q <= 1'b0;
    else        err_q <= accept && (in_last_i != last_data);
  end
  assign err_o = err_q;
`else
  logic unused_last;
  assign unused_last = in_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_rs_stream_par_encoder.sv
// Directed bench for rs_stream_par_encoder: beat scoreboard plus a serial codeword-remainder checker.
`timescale 1ns/1ps
module tb_rs_stream_par_encoder;

  localparam int W  = 10;
  localparam int K  = 522;
  localparam int R  = 22;
  localparam int L  = 7;
  localparam int KB = 75;
  localparam int PB = 4;
  localparam int ZP = 3;
  localparam int BW = L * W;
  localparam int EW = 2 + L + BW;
  localparam int PW = 2 * W - 1;
  localparam logic [W:0]    PRIM_POLY = 11'h409;
  localparam logic [BW-1:0] PAD_MASK  = {{((L - ZP) * W){1'b1}}, {(ZP * W){1'b0}}};
  localparam logic [L-1:0]  KEEP0     = 7'b1111000;
  // g21 .. g0; a message holding only data_k[0]=1 encodes to exactly this parity stream
  localparam int G_STREAM [R] = '{513, 783, 899, 452, 976, 555, 482, 374, 544, 374, 466,
                                  712, 813, 1010, 657, 365, 3, 177, 621, 944, 280, 807};
`ifdef RS_ENC_FRAME_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [BW-1:0] in_data_i;
  logic          in_last_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [BW-1:0] out_data_o;
  logic [L-1:0]  out_keep_o;
  logic          out_last_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q [$];
  logic [BW-1:0] beats [KB];
  logic [W-1:0]  psym [R];
  logic [BW-1:0] par_cap [PB];
  logic [W-1:0]  chk_rem [R];
  logic [EW-1:0] mon_e;
  logic [W-1:0]  rem_or;
  int hs_cnt = 0;
  int frames_done = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int err_seen = 0;
  int err_base;

  rs_stream_par_encoder #(.W(W), .PRIM_POLY(PRIM_POLY), .K(K), .R(R), .L(L)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_keep_o  (out_keep_o),
    .out_last_o  (out_last_o),
    .err_o       (err_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) if (b[i]) p = p ^ (PW'(a) << i);
    for (int i = PW - 1; i >= W; i--) if (p[i]) p = p ^ (PW'(PRIM_POLY) << (i - W));
    return p[W-1:0];
  endfunction

  task automatic chk_feed(input logic [W-1:0] s);
    logic [W-1:0] f;
    f = chk_rem[R-1] ^ s;
    for (int i = R - 1; i > 0; i--) chk_rem[i] = chk_rem[i-1] ^ gf_mul(W'(G_STREAM[R-1-i]), f);
    chk_rem[0] = gf_mul(W'(G_STREAM[R-1]), f);
  endtask

  function automatic logic [BW-1:0] par_beat(input int p);
    logic [BW-1:0] d;
    d = '0;
    for (int j = 0; j < L; j++) if (p * L + j < R) d[j*W +: W] = psym[p*L+j];
    return d;
  endfunction

  task automatic push_parity(input bit chk);
    logic [L-1:0] kp;
    for (int p = 0; p < PB; p++) begin
      kp = '0;
      for (int j = 0; j < L; j++) if (p * L + j < R) kp[j] = 1'b1;
      exp_q.push_back({chk, (p == PB - 1), kp, par_beat(p)});
    end
  endtask

  task automatic set_psym_g();
    for (int m = 0; m < R; m++) psym[m] = W'(G_STREAM[m]);
  endtask

  task automatic fill_single();
    for (int b = 0; b < KB; b++) beats[b] = '0;
    beats[KB-1][6*W +: W] = 10'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_data_i  = '0;
    rst_ni     = 1'b1;
    #1;
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, '0);
    check("rst_out_keep", out_keep_o, '0);
    check("rst_out_last", out_last_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    exp_q.delete();
    hs_cnt = 0;
    foreach (chk_rem[i]) chk_rem[i] = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    check("post_rst_in_ready", in_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input int stop_beat, input int stall_beat, input int lastflag_beat);
    int n;
    for (int b = 0; b < KB; b++) begin
      if (b == stop_beat) return;
      if (b == stall_beat) begin
        out_ready_i = 1'b0;
        #1;
        check("stall_in_ready", in_ready_o, 1'b0);
        repeat (5) begin
          @(negedge clk_i);
          check("stall_hold_valid", out_valid_o, 1'b1);
          check("stall_hold_data", out_data_o, beats[b-1]);
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
      in_valid_i = 1'b1;
      in_data_i  = beats[b];
      in_last_i  = (b == KB - 1) || (b == lastflag_beat);
      exp_q.push_back({1'b1, 1'b0, (b == 0) ? KEEP0 : {L{1'b1}},
                       (b == 0) ? (beats[b] & PAD_MASK) : beats[b]});
      n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (in_ready_o !== 1'b1 && n < 100);
      if (in_ready_o !== 1'b1) check("in_ready_timeout", in_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      if (b == lastflag_beat) begin
        @(negedge clk_i);
        check("err_pulse", err_o, EXP_ERR);
        @(negedge clk_i);
        check("err_single_cycle", err_o, 1'b0);
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("frame_done", frames_done, target);
    check("queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_i) begin
    cyc++;
    if (err_o === 1'b1) err_seen++;
    if (rst_ni === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (hs_cnt == 0) first_cyc = cyc;
        check("out_keep", out_keep_o, mon_e[BW +: L]);
        check("out_last", out_last_o, mon_e[BW+L]);
        if (mon_e[EW-1]) check("out_data", out_data_o, mon_e[BW-1:0]);
      end
      if (hs_cnt >= KB && hs_cnt < KB + PB) par_cap[hs_cnt-KB] = out_data_o;
      for (int j = 0; j < L; j++) if (out_keep_o[j]) chk_feed(out_data_o[j*W +: W]);
      hs_cnt++;
      if (out_last_o === 1'b1) begin
        last_cyc = cyc;
        rem_or = '0;
        foreach (chk_rem[i]) rem_or = rem_or | chk_rem[i];
        check("codeword_remainder", rem_or, '0);
        check("frame_beats", hs_cnt, KB + PB);
        foreach (chk_rem[i]) chk_rem[i] = '0;
        hs_cnt = 0;
        frames_done++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_ni      = 1'b0;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    in_data_i   = '0;
    foreach (chk_rem[i]) chk_rem[i] = '0;
    #1;
    do_reset();

    // all-zero message, continuous ready
    for (int b = 0; b < KB; b++) beats[b] = '0;
    for (int m = 0; m < R; m++) psym[m] = '0;
    send_frame(-1, -1, -1);
    push_parity(1'b1);
    wait_frames(1);
    check("no_bubbles", last_cyc - first_cyc, KB + PB - 1);

    // single nonzero symbol: parity equals generator taps
    fill_single();
    set_psym_g();
    send_frame(-1, -1, -1);
    push_parity(1'b1);
    wait_frames(2);

    // random messages, including random pad lanes
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < KB; b++)
        for (int j = 0; j < L; j++) beats[b][j*W +: W] = W'($urandom_range(0, 1023));
      send_frame(-1, -1, -1);
      push_parity(1'b0);
      wait_frames(3 + s);
    end

    // same message again with output stalls at beat 40 and on parity beat 1
    for (int m = 0; m < R; m++) psym[m] = par_cap[m/L][(m%L)*W +: W];
    send_frame(-1, 40, -1);
    push_parity(1'b1);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
    check("par_stall_position", hs_cnt, KB + 1);
    #1;
    check("par_stall_in_ready", in_ready_o, 1'b0);
    repeat (5) begin
      @(negedge clk_i);
      check("par_hold_valid", out_valid_o, 1'b1);
      check("par_hold_data", out_data_o, par_beat(1));
    end
    @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    wait_frames(6);

    // garbage on the pad lanes must not reach the encoder or the output
    fill_single();
    beats[0][0*W +: W] = 10'h3FF;
    beats[0][1*W +: W] = 10'h155;
    beats[0][2*W +: W] = 10'h2AA;
    set_psym_g();
    send_frame(-1, -1, -1);
    push_parity(1'b1);
    wait_frames(7);
    check("no_err_so_far", err_seen, 0);

    // early in_last_i on beat 40: flagged when checking is built in, frame still runs to beat 74
    err_base = err_seen;
    fill_single();
    set_psym_g();
    send_frame(-1, -1, 40);
    push_parity(1'b1);
    wait_frames(8);
    check("err_count", err_seen - err_base, EXP_ERR);

    // reset at beat 30, then a fresh frame
    for (int b = 0; b < KB; b++) beats[b] = {BW{1'b1}};
    send_frame(30, -1, -1);
    do_reset();
    check("mid_rst_queue", exp_q.size(), 0);
    fill_single();
    set_psym_g();
    send_frame(-1, -1, -1);
    push_parity(1'b1);
    wait_frames(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_stream_par_encoder.md
# rs_stream_par_encoder

Parametrised streaming systematic Reed-Solomon encoder with L symbol lanes per beat, valid/ready on both sides. It accepts one message of K symbols as ceil(K/L) beats and forwards them unchanged. It then appends the R parity symbols as ceil(R/L) beats, so the output is a complete codeword stream. It sits between the framer and the PMA gearbox and generalises the fixed-L, parity-only RS(544,522) matrix encoder.

## Interface
- W, 10: symbol width in bits (GF(2^W)).
- PRIM_POLY, 11'h409: field primitive polynomial, W+1 bits (x^10+x^3+1).
- K, 522: message symbols per codeword.
- R, 22: parity symbols (N = K+R).
- L, 7: lanes per beat, 1..R.
- G_TAPS, {g21..g0} = {513,783,899,452,976,555,482,374,544,374,466,712,813,1010,657,365,3,177,621,944,280,807}: R*W-bit generator coefficients, g0 in the LSBs; monic term implied.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid&ready.
- in_data_i  in  L*W  lane j at bits [j*W +: W]; lane 0 is the earliest (highest-degree) symbol.
- in_last_i  in  1  upstream end-of-message marker.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  L*W  codeword beat, same lane order.
- out_keep_o  out  L  per-lane valid mask.
- out_last_o  out  1  final beat of codeword.
- err_o  out  1  framing error pulse (see Configuration).

## Operation
- Derived constants:
  - ZP = (L - K%L)%L front-pad lanes.
  - KB = (K+ZP)/L data beats.
  - PB = ceil(R/L) parity beats.
- FSM states:
  - DATA (reset state): accepts beats.
  - PAR: emits parity beats; in_ready_o=0.
- Beat counter bcnt counts 0..KB-1 in DATA and 0..PB-1 in PAR. Width $clog2(max(KB,PB)+1).
- DATA beat 0: lanes 0..ZP-1 are forced to zero before the LFSR and on out_data_o, regardless of input, and their out_keep_o bits are 0. All other data lanes have keep=1.
- Each accepted data beat applies L unrolled LFSR steps in lane order, all in one cycle:
  - f = rem[R-1] ^ s
  - rem'[0] = g0*f
  - rem'[i] = rem[i-1] ^ gi*f
- The GF multiply is reduced modulo PRIM_POLY.
- On acceptance of the data beat with bcnt=KB-1:
  - rem is latched into the parity register.
  - rem is cleared.
  - The FSM goes to PAR.
- PAR beat p, lane j carries p[R-1-(p*L+j)] with keep=1 when p*L+j < R; otherwise the lane is 0 with keep=0.
- out_last_o=1 on parity beat PB-1.
- After PAR beat PB-1 is loaded into the output register, the FSM returns to DATA with bcnt=0.
- The output is a single register stage: in_ready_o = (state==DATA) & (!out_valid_o | out_ready_i).
- The output register holds while out_valid_o & !out_ready_i.

## Timing
- Reset values:
  - in_ready_o=0 during reset, then 1 from the first cycle after reset.
  - out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, err_o=0.
  - rem=0, state=DATA, bcnt=0.
- Latency: a data beat accepted at edge n appears on the output from edge n.
- Parity beat 0 is loaded on the edge where the last data beat is handshaked out. There are no bubbles, so a codeword takes exactly KB+PB output beats under continuous ready.
- Reset mid-frame: all state is discarded and the next accepted beat is beat 0 of a new frame.
- Simultaneous out handshake and new in handshake in the same cycle: the register is replaced with no loss.
- in_valid_i may drop between beats; frame position is kept.

## Configuration
- RS_ENC_FRAME_CHECK_EN defined: on each accepted data beat, err_o pulses for one cycle when in_last_i != (bcnt==KB-1).
  - Framing always follows bcnt; in_last_i never alters sequencing.
- RS_ENC_FRAME_CHECK_EN undefined: in_last_i is ignored and err_o is tied 0.

## Test plan
- Default params, all-zero message, continuous ready:
  - 75 data beats then 4 parity beats, all parity 0.
  - Beat 0 keep = lanes 3..6.
  - Last beat keep = lane 0 only, with out_last_o=1.
- Single nonzero symbol data_k[0]=1 (beat 74, lane 6): parity beats carry p21..p0 = 513,783,...,280,807, i.e. p[i]=g_i.
- Random message (3 seeds): codeword stream fed serially MSB-first through the 22-stage LFSR checker gives an all-zero remainder.
- Nonzero garbage on beat-0 pad lanes: parity is identical to the zero-pad run and out lanes 0..2 are 0.
- out_ready_i low for 5 cycles at beat 40 and during parity beat 1: in_ready_o falls the same cycle, the output is held stable, and the codeword is bit-exact.
- Checked feature: in_last_i=1 on beat 40 gives an err_o single-cycle pulse, and the frame still completes at beat 74. Separately, rst_ni pulsed at beat 30 followed by a fresh frame gives correct parity.
